// File: rtl/branch_resolve_bht.sv
// EX-stage branch resolution with a 2-bit saturating-counter branch history table.
// Optional resolved/mispredict statistics counters are enabled by defining BP_STATS_EN.
module branch_resolve_bht #(
  parameter int unsigned IDX_W    = 6,
  parameter logic [1:0]  CNT_INIT = 2'b10
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic [31:0] if_pc,
  output logic        if_pred_taken,
  input  logic        ex_valid,
  input  logic        ex_is_branch,
  input  logic        ex_is_jump,
  input  logic        ex_taken,
  input  logic        ex_pred_taken,
  input  logic [31:0] ex_pc,
  input  logic [31:0] ex_br_target,
  input  logic [31:0] ex_jmp_target,
  output logic [1:0]  Nexttype,
  output logic [31:0] redirect_pc,
  output logic [31:0] br_cnt,
  output logic [31:0] mis_cnt
);

  typedef enum logic [1:0] {
    NT_PCPLUS4  = 2'b00,
    NT_BRANCH   = 2'b01,
    NT_BR_WRONG = 2'b10,
    NT_JUMP     = 2'b11
  } nexttype_e;

  localparam int unsigned DEPTH = 1 << IDX_W;

  logic [1:0]       r_bht [DEPTH];
  logic [IDX_W-1:0] w_if_idx;
  logic [IDX_W-1:0] w_ex_idx;
  logic [1:0]       w_cnt_cur;
  logic [1:0]       w_cnt_next;
  logic             w_train;
  logic [31:0]      w_pc_plus4;
  nexttype_e        w_nt;
  logic [31:0]      w_redirect;
  logic             w_unused;

  assign w_if_idx   = if_pc[IDX_W+1:2];
  assign w_ex_idx   = ex_pc[IDX_W+1:2];
  assign w_pc_plus4 = ex_pc + 32'd4;
  assign w_unused   = ^{if_pc[31:IDX_W+2], if_pc[1:0]};

  // A jump that also carries the branch flag never trains the table.
  assign w_train = rstn & ex_valid & ex_is_branch & ~ex_is_jump;

  // Lookup reads the stored value only; a same-cycle update is seen next cycle.
  assign if_pred_taken = rstn ? r_bht[w_if_idx][1] : 1'b0;

  always_comb begin
    w_nt       = NT_PCPLUS4;
    w_redirect = w_pc_plus4;
    if (!ex_valid) begin
      w_nt       = NT_PCPLUS4;
      w_redirect = w_pc_plus4;
    end else if (ex_is_jump) begin
      w_nt       = NT_JUMP;
      w_redirect = ex_jmp_target;
    end else if (ex_is_branch) begin
      if (ex_taken == ex_pred_taken) begin
        w_nt       = NT_BRANCH;
        w_redirect = w_pc_plus4;
      end else begin
        w_nt       = NT_BR_WRONG;
        w_redirect = ex_taken ? ex_br_target : w_pc_plus4;
      end
    end
  end

  assign Nexttype    = rstn ? w_nt : NT_PCPLUS4;
  assign redirect_pc = rstn ? w_redirect : '0;

  assign w_cnt_cur = r_bht[w_ex_idx];

  always_comb begin
    w_cnt_next = w_cnt_cur;
    if (ex_taken) begin
      if (w_cnt_cur != 2'b11) w_cnt_next = w_cnt_cur + 2'b01;
    end else begin
      if (w_cnt_cur != 2'b00) w_cnt_next = w_cnt_cur - 2'b01;
    end
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      for (int unsigned i = 0; i < DEPTH; i++) r_bht[i] <= CNT_INIT;
    end else if (w_train) begin
      r_bht[w_ex_idx] <= w_cnt_next;
    end
  end

`ifdef BP_STATS_EN
  logic [31:0] r_br_cnt;
  logic [31:0] r_mis_cnt;
  logic        w_mispred;

  assign w_mispred = w_train & (ex_taken != ex_pred_taken);

  always_ff @(posedge clk) begin
    if (!rstn) begin
      r_br_cnt  <= '0;
      r_mis_cnt <= '0;
    end else begin
      if (w_train && (r_br_cnt != '1))   r_br_cnt  <= r_br_cnt + 32'd1;
      if (w_mispred && (r_mis_cnt != '1)) r_mis_cnt <= r_mis_cnt + 32'd1;
    end
  end

  assign br_cnt  = r_br_cnt;
  assign mis_cnt = r_mis_cnt;
`else
  assign br_cnt  = '0;
  assign mis_cnt = '0;
`endif

endmodule

// File: tb/tb_branch_resolve_bht.sv
// Scoreboard bench for branch_resolve_bht: directed scenarios then random traffic,
// checked against a behavioural table model.
module tb_branch_resolve_bht;

  logic        clk = 1'b0;
  logic        rstn;
  logic [31:0] if_pc;
  logic        if_pred_taken;
  logic        ex_valid, ex_is_branch, ex_is_jump, ex_taken, ex_pred_taken;
  logic [31:0] ex_pc, ex_br_target, ex_jmp_target;
  logic [1:0]  Nexttype;
  logic [31:0] redirect_pc, br_cnt, mis_cnt;

  branch_resolve_bht #(.IDX_W(6), .CNT_INIT(2'b10)) dut (
    .clk(clk), .rstn(rstn), .if_pc(if_pc), .if_pred_taken(if_pred_taken),
    .ex_valid(ex_valid), .ex_is_branch(ex_is_branch), .ex_is_jump(ex_is_jump),
    .ex_taken(ex_taken), .ex_pred_taken(ex_pred_taken), .ex_pc(ex_pc),
    .ex_br_target(ex_br_target), .ex_jmp_target(ex_jmp_target),
    .Nexttype(Nexttype), .redirect_pc(redirect_pc), .br_cnt(br_cnt), .mis_cnt(mis_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        pred;
    logic [1:0]  nt;
    logic [31:0] rpc;
    logic [31:0] brc;
    logic [31:0] misc;
  } exp_t;

  exp_t q[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  // Reference model state: plain integer counters 0..3 per table slot.
  int          m_bht [64];
  logic [31:0] m_brc, m_misc;
  bit          p_rst   = 1'b1;
  bit          p_train = 1'b0;
  bit          p_taken, p_mis;
  int          p_idx;

  // Stimulus variables
  logic        s_rstn = 1'b0, s_valid = 1'b0, s_br = 1'b0, s_jmp = 1'b0;
  logic        s_taken = 1'b0, s_pred = 1'b0;
  logic [31:0] s_if_pc = '0, s_pc = '0, s_brt = '0, s_jmt = '0;

  initial begin
    rstn = 1'b0; if_pc = '0; ex_valid = 1'b0; ex_is_branch = 1'b0; ex_is_jump = 1'b0;
    ex_taken = 1'b0; ex_pred_taken = 1'b0; ex_pc = '0; ex_br_target = '0; ex_jmp_target = '0;
  end

  function automatic int idx_of(logic [31:0] pc);
    return int'((pc >> 2) & 32'h3F);
  endfunction

  task automatic step();
    exp_t e;
    @(posedge clk); #1;
    if (p_rst) begin
      for (int i = 0; i < 64; i++) m_bht[i] = 2;
      m_brc = '0; m_misc = '0;
    end else if (p_train) begin
      if (p_taken) m_bht[p_idx] = (m_bht[p_idx] < 3) ? m_bht[p_idx] + 1 : 3;
      else         m_bht[p_idx] = (m_bht[p_idx] > 0) ? m_bht[p_idx] - 1 : 0;
`ifdef BP_STATS_EN
      if (m_brc != 32'hFFFF_FFFF) m_brc = m_brc + 1;
      if (p_mis && m_misc != 32'hFFFF_FFFF) m_misc = m_misc + 1;
`endif
    end
    rstn = s_rstn; if_pc = s_if_pc; ex_valid = s_valid; ex_is_branch = s_br;
    ex_is_jump = s_jmp; ex_taken = s_taken; ex_pred_taken = s_pred; ex_pc = s_pc;
    ex_br_target = s_brt; ex_jmp_target = s_jmt;
    if (!s_rstn) begin
      e.pred = 1'b0; e.nt = 2'b00; e.rpc = 32'h0;
    end else begin
      e.pred = (m_bht[idx_of(s_if_pc)] >= 2);
      if (!s_valid)              begin e.nt = 2'b00; e.rpc = s_pc + 32'd4; end
      else if (s_jmp)            begin e.nt = 2'b11; e.rpc = s_jmt; end
      else if (s_br && s_taken == s_pred) begin e.nt = 2'b01; e.rpc = s_pc + 32'd4; end
      else if (s_br)             begin e.nt = 2'b10; e.rpc = s_taken ? s_brt : s_pc + 32'd4; end
      else                       begin e.nt = 2'b00; e.rpc = s_pc + 32'd4; end
    end
    e.brc = m_brc; e.misc = m_misc;
    q.push_back(e);
    p_rst   = !s_rstn;
    p_train = s_rstn && s_valid && s_br && !s_jmp;
    p_taken = s_taken;
    p_mis   = (s_taken != s_pred);
    p_idx   = idx_of(s_pc);
  endtask

  task automatic chk(string name, logic [31:0] act, logic [31:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s @%0t: got 0x%08h expected 0x%08h", name, $time, act, req);
    end
  endtask

  // Monitor: one expected record per cycle, compared mid-cycle.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (q.size() > 0) begin
        e = q.pop_front();
        chk("if_pred_taken", {31'b0, if_pred_taken}, {31'b0, e.pred});
        chk("Nexttype", {30'b0, Nexttype}, {30'b0, e.nt});
        chk("redirect_pc", redirect_pc, e.rpc);
        chk("br_cnt", br_cnt, e.brc);
        chk("mis_cnt", mis_cnt, e.misc);
      end
    end
  end

  task automatic ex_idle();
    s_valid = 1'b0; s_br = 1'b0; s_jmp = 1'b0; s_taken = 1'b0; s_pred = 1'b0;
  endtask

  initial begin
    int unsigned r;
    logic [31:0] pcs [8];
    pcs[0] = 32'h100; pcs[1] = 32'h200; pcs[2] = 32'h300; pcs[3] = 32'h1100;
    pcs[4] = 32'h500; pcs[5] = 32'hFFFF_FFFC; pcs[6] = 32'h40; pcs[7] = 32'h2300;

    // Reset, then first lookup
    s_rstn = 1'b0; repeat (2) step();
    s_rstn = 1'b1; s_if_pc = 32'h40; step();
    // Mispredict, predicted taken
    s_valid = 1; s_br = 1; s_pc = 32'h100; s_pred = 1; s_taken = 0; step();
    ex_idle(); s_if_pc = 32'h100; step();
    // Mispredict, predicted not-taken
    s_valid = 1; s_br = 1; s_pc = 32'h200; s_brt = 32'h180; s_pred = 0; s_taken = 1; step();
    // Saturation at 0x300
    s_if_pc = 32'h300; s_pc = 32'h300; s_brt = 32'h380; s_pred = 1; s_taken = 1;
    repeat (5) step();
    s_taken = 0; step();
    ex_idle(); step();
    // Jump priority over branch
    s_valid = 1; s_jmp = 1; s_br = 1; s_jmt = 32'h400; s_taken = 1; step();
    ex_idle(); step();
    // Bubble carrying branch flag
    s_br = 1; s_pc = 32'h500; s_taken = 0; step();
    // Same-cycle lookup and training of one index
    s_if_pc = 32'h500; s_valid = 1; s_br = 1; s_pred = 1; s_taken = 0; step();
    ex_idle(); step();
    // PC wrap
    s_pc = 32'hFFFF_FFFC; step();
    s_valid = 1; s_br = 1; s_pred = 1; s_taken = 0; step();
    ex_idle();

    // Random traffic over a small aliasing PC set
    for (int n = 0; n < 3000; n++) begin
      r = $urandom;
      s_rstn  = ($urandom_range(0, 199) != 0);
      s_if_pc = pcs[$urandom_range(0, 7)];
      s_pc    = pcs[$urandom_range(0, 7)];
      s_valid = ($urandom_range(0, 7) != 0);
      s_br    = r[0] | r[1];
      s_jmp   = (r[4:2] == 3'b000);
      s_taken = r[5];
      s_pred  = r[6];
      s_brt   = $urandom;
      s_jmt   = $urandom;
      step();
    end

    for (int k = 0; k < 10 && q.size() > 0; k++) @(posedge clk);
    n_checks++;
    if (q.size() != 0) begin
      n_fail++;
      $display("FAIL drain: %0d records left, expected 0", q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

endmodule
